// File: rtl/tnn_infer_pkg.sv
// rtl/tnn_infer_pkg.sv - shared types and constants for the TNN inference controller
package tnn_infer_pkg;

  // Feature packing: five 2-bit features a..e, a in the low bits.
  localparam int FEAT_W   = 2;
  localparam int N_FEAT   = 5;
  localparam int VEC_W    = FEAT_W * N_FEAT;

  // Settle counter width; covers EVAL_CYCLES up to 15.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tnn_sat_counter.sv
// rtl/tnn_sat_counter.sv - saturating up-counter with synchronous clear
module tnn_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tnn_infer_ctrl.sv
// rtl/tnn_infer_ctrl.sv - sample/settle/result sequencer around an external classifier; statistics under TNN_INFER_STATS_EN
module tnn_infer_ctrl
  import tnn_infer_pkg::*;
#(
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [VEC_W-1:0] s_feat,
  output logic [VEC_W-1:0] core_feat,
  input  logic             core_class,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_class
`ifdef TNN_INFER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_pos
`endif
);

  // Settle count value on the edge that captures the classifier output.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(EVAL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [VEC_W-1:0]    feat_q, feat_d;
  logic                class_q, class_d;
  logic                capture;

  // Next-state, handshake outputs and datapath load enables.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    feat_d   = feat_q;
    class_d  = class_q;
    capture  = 1'b0;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          feat_d   = s_feat;
          settle_d = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (settle_q == SETTLE_LAST) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The class bit is only ever sampled on the capture edge.
    if (capture) begin
      class_d = core_class;
    end
  end

  // State and datapath registers; reset drops any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      feat_q   <= '0;
      class_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      feat_q   <= feat_d;
      class_q  <= class_d;
    end
  end

  assign core_feat = feat_q;
  assign m_class   = class_q;

`ifdef TNN_INFER_STATS_EN
  // Positive count only advances alongside the total, so it cannot overtake it.
  tnn_sat_counter #(
    .W(CNT_W)
  ) u_cnt_total (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stats_clr),
    .inc  (capture),
    .cnt  (cnt_total)
  );

  tnn_sat_counter #(
    .W(CNT_W)
  ) u_cnt_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stats_clr),
    .inc  (capture & core_class),
    .cnt  (cnt_pos)
  );
`else
  // Counter width is meaningless without statistics; keep the parameter referenced.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_tnn_infer_ctrl.sv
// tb/tb_tnn_infer_ctrl.sv - directed scoreboard bench for tnn_infer_ctrl
module tb_tnn_infer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference classifier: sum of the five 2-bit features >= 6.
  function automatic logic cls(input logic [9:0] f);
    int s;
    s = int'(f[1:0]) + int'(f[3:2]) + int'(f[5:4]) + int'(f[7:6]) + int'(f[9:8]);
    return (s >= 6);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance 1: EVAL_CYCLES=1, CNT_W=16
  logic       s_valid1 = 0, s_ready1, core_class1, m_valid1, m_ready1 = 0, m_class1;
  logic [9:0] s_feat1 = '0, core_feat1;
  // Instance 3: EVAL_CYCLES=3, CNT_W=16
  logic       s_valid3 = 0, s_ready3, core_class3, m_valid3, m_ready3 = 0, m_class3;
  logic [9:0] s_feat3 = '0, core_feat3;
  logic       flip3 = 0;
  // Instance 4: EVAL_CYCLES=1, CNT_W=4
  logic       s_valid4 = 0, s_ready4, core_class4, m_valid4, m_ready4 = 0, m_class4;
  logic [9:0] s_feat4 = '0, core_feat4;

  assign core_class1 = cls(core_feat1);
  assign core_class3 = cls(core_feat3) ^ flip3;
  assign core_class4 = cls(core_feat4);

`ifdef TNN_INFER_STATS_EN
  logic        stats_clr1 = 0, stats_clr3 = 0, stats_clr4 = 0;
  logic [15:0] cnt_total1, cnt_pos1, cnt_total3, cnt_pos3;
  logic [3:0]  cnt_total4, cnt_pos4;
`endif

  tnn_infer_ctrl #(.EVAL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_feat(s_feat1),
    .core_feat(core_feat1), .core_class(core_class1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_class(m_class1)
`ifdef TNN_INFER_STATS_EN
    , .stats_clr(stats_clr1), .cnt_total(cnt_total1), .cnt_pos(cnt_pos1)
`endif
  );

  tnn_infer_ctrl #(.EVAL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_ready(s_ready3), .s_feat(s_feat3),
    .core_feat(core_feat3), .core_class(core_class3), .m_valid(m_valid3), .m_ready(m_ready3),
    .m_class(m_class3)
`ifdef TNN_INFER_STATS_EN
    , .stats_clr(stats_clr3), .cnt_total(cnt_total3), .cnt_pos(cnt_pos3)
`endif
  );

  tnn_infer_ctrl #(.EVAL_CYCLES(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4), .s_feat(s_feat4),
    .core_feat(core_feat4), .core_class(core_class4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_class(m_class4)
`ifdef TNN_INFER_STATS_EN
    , .stats_clr(stats_clr4), .cnt_total(cnt_total4), .cnt_pos(cnt_pos4)
`endif
  );

  logic [9:0] feats [8] = '{10'h2A5, 10'h000, 10'h3FF, 10'h155, 10'h0F0, 10'h003, 10'h3C3, 10'h10A};
  logic       exp_q [$];

  initial begin
    int idx, nres, last_t, npos, seen;
    logic e;

    // Reset state
    tick();
    tick();
    chk("rst_s_ready1", s_ready1, 1);
    chk("rst_m_valid1", m_valid1, 0);
    chk("rst_m_class1", m_class1, 0);
    chk("rst_core_feat1", core_feat1, 0);
    chk("rst_s_ready3", s_ready3, 1);
    chk("rst_m_valid4", m_valid4, 0);
`ifdef TNN_INFER_STATS_EN
    chk("rst_cnt_total1", cnt_total1, 0);
    chk("rst_cnt_pos1", cnt_pos1, 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_s_ready_no_valid", s_ready1, 1);

    // Single sample, EVAL_CYCLES=1
    s_valid1 = 1; s_feat1 = 10'h2A5;
    tick();
    s_valid1 = 0; s_feat1 = 10'h3FF;
    chk("a_core_feat", core_feat1, 10'h2A5);
    chk("a_s_ready_eval", s_ready1, 0);
    chk("a_m_valid_eval", m_valid1, 0);
    tick();
    chk("a_m_valid", m_valid1, 1);
    chk("a_m_class", m_class1, 1);
    m_ready1 = 1;
    tick();
    m_ready1 = 0;
    chk("a_m_valid_after", m_valid1, 0);
    chk("a_s_ready_after", s_ready1, 1);
    chk("a_core_feat_held", core_feat1, 10'h2A5);
`ifdef TNN_INFER_STATS_EN
    chk("a_cnt_total", cnt_total1, 1);
    chk("a_cnt_pos", cnt_pos1, 1);
`endif

    // Backpressure hold, EVAL_CYCLES=3
    s_valid3 = 1; s_feat3 = 10'h3C3;
    tick();
    s_feat3 = 10'h000;
    chk("b_core_feat", core_feat3, 10'h3C3);
    chk("b_m_valid_e0", m_valid3, 0);
    tick();
    chk("b_m_valid_e1", m_valid3, 0);
    tick();
    chk("b_m_valid_e2", m_valid3, 0);
    tick();
    chk("b_m_valid_e3", m_valid3, 1);
    chk("b_m_class_e3", m_class3, 1);
    flip3 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b_hold_m_valid", m_valid3, 1);
      chk("b_hold_m_class", m_class3, 1);
      chk("b_hold_s_ready", s_ready3, 0);
      chk("b_hold_core_feat", core_feat3, 10'h3C3);
    end
    flip3 = 0;
    m_ready3 = 1;
    tick();
    m_ready3 = 0; s_valid3 = 0;
    chk("b_release_m_valid", m_valid3, 0);
    chk("b_release_s_ready", s_ready3, 1);
    chk("b_no_same_edge_accept", core_feat3, 10'h3C3);

    // Streaming 8 samples, EVAL_CYCLES=1
`ifdef TNN_INFER_STATS_EN
    stats_clr1 = 1;
    tick();
    stats_clr1 = 0;
    chk("c_clr_total", cnt_total1, 0);
`endif
    idx = 0; nres = 0; last_t = 0; npos = 0;
    s_valid1 = 1; m_ready1 = 1;
    for (int c = 0; c < 60 && nres < 8; c++) begin
      if (m_valid1) begin
        if (exp_q.size() == 0) begin
          chk("c_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("c_class", m_class1, e);
        end
        if (nres > 0) chk("c_gap", c - last_t, 3);
        last_t = c;
        nres++;
      end
      if (s_ready1) begin
        if (idx < 8) begin
          s_feat1 = feats[idx];
          exp_q.push_back(cls(feats[idx]));
          if (cls(feats[idx])) npos++;
          idx++;
        end else begin
          s_valid1 = 0;
        end
      end
      tick();
    end
    s_valid1 = 0; m_ready1 = 0;
    chk("c_result_count", nres, 8);
`ifdef TNN_INFER_STATS_EN
    chk("c_cnt_total", cnt_total1, 8);
    chk("c_cnt_pos", cnt_pos1, npos);
`endif

    // Saturation with CNT_W=4, then clear coincident with a capture
    nres = 0;
    s_valid4 = 1; s_feat4 = 10'h3FF; m_ready4 = 1;
    for (int c = 0; c < 100 && nres < 20; c++) begin
      if (m_valid4) begin
        chk("d_class", m_class4, 1);
        nres++;
      end
      tick();
    end
    chk("d_result_count", nres, 20);
`ifdef TNN_INFER_STATS_EN
    chk("d_sat_total", cnt_total4, 15);
    chk("d_sat_pos", cnt_pos4, 15);
`endif
    for (int c = 0; c < 5 && !s_ready4; c++) tick();
    chk("d_idle_before_clr", s_ready4, 1);
    tick();
`ifdef TNN_INFER_STATS_EN
    stats_clr4 = 1;
`endif
    tick();
`ifdef TNN_INFER_STATS_EN
    stats_clr4 = 0;
`endif
    s_valid4 = 0;
    chk("d_capture_m_valid", m_valid4, 1);
`ifdef TNN_INFER_STATS_EN
    chk("d_clr_total", cnt_total4, 0);
    chk("d_clr_pos", cnt_pos4, 0);
`endif
    tick();
    m_ready4 = 0;

    // Reset mid-EVAL on EVAL_CYCLES=3
`ifdef TNN_INFER_STATS_EN
    chk("e_pre_total3", cnt_total3, 1);
`endif
    s_valid3 = 1; s_feat3 = 10'h3FF; m_ready3 = 0;
    tick();
    s_valid3 = 0;
    chk("e_in_eval", s_ready3, 0);
    tick();
    rst_n = 0;
    #1;
    chk("e_async_s_ready", s_ready3, 1);
    chk("e_async_m_valid", m_valid3, 0);
    chk("e_async_core_feat", core_feat3, 0);
    tick();
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (m_valid3) seen++;
    end
    chk("e_no_result", seen, 0);
    chk("e_s_ready", s_ready3, 1);
    chk("e_m_class", m_class3, 0);
`ifdef TNN_INFER_STATS_EN
    chk("e_cnt_total3", cnt_total3, 0);
    chk("e_cnt_pos3", cnt_pos3, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
